// File: rtl/joy_pkg.sv
// Shared constants and FSM encoding for the joystick splitter scanner.
// Player vectors are active-low, so "released" is all ones.
package joy_pkg;

  localparam int unsigned JOY_W = 6;
  localparam logic [JOY_W-1:0] JOY_RELEASED = 6'h3F;

  typedef logic [2:0] joy_state_t;

  localparam joy_state_t IDLE     = 3'd0;
  localparam joy_state_t SETTLE_A = 3'd1;
  localparam joy_state_t SAMPLE_A = 3'd2;
  localparam joy_state_t SETTLE_B = 3'd3;
  localparam joy_state_t SAMPLE_B = 3'd4;
  localparam joy_state_t DONE     = 3'd5;

  // Splitter select for a given state: player 2 is routed from SETTLE_B through DONE.
  function automatic logic state_sel(joy_state_t s);
    return (s == SETTLE_B) || (s == SAMPLE_B) || (s == DONE);
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit consecutive-sample debouncer for one 6-bit active-low player vector.
// An output bit flips only after DEBOUNCE_SAMPLES strobed samples disagree with it in a row.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [JOY_W-1:0] sample,
  input  logic             strobe,
  output logic [JOY_W-1:0] vector
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES - 1);

  if ((DEBOUNCE_SAMPLES < 1) || (DEBOUNCE_SAMPLES > 15)) begin : g_bad_debounce
    $error("joy_debounce: DEBOUNCE_SAMPLES must be in 1..15");
  end

  logic [CW-1:0]    cnt_q [JOY_W];
  logic [CW-1:0]    cnt_d [JOY_W];
  logic [JOY_W-1:0] vec_q;
  logic [JOY_W-1:0] vec_d;

  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (strobe) begin
      for (int i = 0; i < JOY_W; i++) begin
        if (sample[i] == vec_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          vec_d[i] = sample[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < JOY_W; i++) begin
        cnt_q[i] <= '0;
      end
      vec_q <= JOY_RELEASED;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
    end
  end

  assign vector = vec_q;

endmodule

// File: rtl/joy_split_scanner.sv
// Sequenced joystick splitter scan: select a player, let the splitter and synchroniser
// settle, take one sample, debounce it, then repeat for the other player.
module joy_split_scanner
  import joy_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 32,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [JOY_W-1:0] joy_in,
  output logic             joy_split_out,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             joy_valid
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Two synchroniser cycles plus at least one cycle of splitter settling are needed.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("joy_split_scanner: SETTLE_CYCLES must be >= 3");
  end

  logic [JOY_W-1:0] sync1_q;
  logic [JOY_W-1:0] sync2_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sync1_q <= JOY_RELEASED;
      sync2_q <= JOY_RELEASED;
    end else begin
      sync1_q <= joy_in;
      sync2_q <= sync1_q;
    end
  end

  joy_state_t       state_q;
  joy_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sel_q;
  logic             sel_d;
  logic             valid_q;
  logic             valid_d;
  logic             strobe_a;
  logic             strobe_b;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  // Counter only advances inside a settle state and is zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     state_d = SETTLE_A;
        SETTLE_A: begin
          if (cnt_q == CNT_LAST) begin
            state_d = SAMPLE_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SAMPLE_A: state_d = SETTLE_B;
        SETTLE_B: begin
          if (cnt_q == CNT_LAST) begin
            state_d = SAMPLE_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SAMPLE_B: state_d = DONE;
        DONE:     state_d = SETTLE_A;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Select and valid are registered from the next state so they line up with state_q.
  always_comb begin
    sel_d    = state_sel(state_d);
    valid_d  = (state_d == DONE);
    strobe_a = enable && (state_q == SAMPLE_A);
    strobe_b = enable && (state_q == SAMPLE_B);
  end

  joy_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce_a (
    .pclk  (pclk),
    .reset (reset),
    .sample(sync2_q),
    .strobe(strobe_a),
    .vector(joystick1)
  );

  joy_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce_b (
    .pclk  (pclk),
    .reset (reset),
    .sample(sync2_q),
    .strobe(strobe_b),
    .vector(joystick2)
  );

  assign joy_split_out = sel_q;
  assign joy_valid     = valid_q;

endmodule

// File: tb/tb_joy_split_scanner.sv
// Scoreboard bench: directed scans push expected player vectors, monitors check on joy_valid.
module tb_joy_split_scanner;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       enable1 = 1'b0;
  logic [5:0] joy_a, joy_b, joy_a1, joy_b1;
  logic [5:0] joy_in, joy_in1;
  logic       sel0, sel1, v0, v1;
  logic [5:0] j1, j2, k1, k2;

  int checks = 0;
  int failures = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] e0, e1;

  always #5 pclk = ~pclk;

  // Splitter model: the routed player depends on the select line.
  assign joy_in  = sel0 ? joy_b : joy_a;
  assign joy_in1 = sel1 ? joy_b1 : joy_a1;

  joy_split_scanner #(
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .enable       (enable),
    .joy_in       (joy_in),
    .joy_split_out(sel0),
    .joystick1    (j1),
    .joystick2    (j2),
    .joy_valid    (v0)
  );

  joy_split_scanner #(
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SAMPLES(1)
  ) dut1 (
    .pclk         (pclk),
    .reset        (reset),
    .enable       (enable1),
    .joy_in       (joy_in1),
    .joy_split_out(sel1),
    .joystick1    (k1),
    .joystick2    (k2),
    .joy_valid    (v1)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (!reset && v0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_dut actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        check("scan_outputs_dut", {j1, j2}, e0);
        check("sel_at_done_dut", {11'h0, sel0}, 12'h001);
      end
    end
  end

  always @(negedge pclk) begin
    if (!reset && v1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_dut1 actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        check("scan_outputs_dut1", {k1, k2}, e1);
      end
    end
  end

  task automatic wait_valid(input bit which, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      got = which ? v1 : v0;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout actual=no_valid required=valid", name);
    end
  endtask

  task automatic scan0(input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] x1, input logic [5:0] x2, input string name);
    joy_a = a;
    joy_b = b;
    q0.push_back({x1, x2});
    wait_valid(1'b0, name);
  endtask

  task automatic scan1(input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] x1, input logic [5:0] x2, input string name);
    joy_a1 = a;
    joy_b1 = b;
    q1.push_back({x1, x2});
    enable1 = 1'b1;
    wait_valid(1'b1, name);
  endtask

  initial begin
    int lows, highs, early, n;
    joy_a  = 6'h00;
    joy_b  = 6'h00;
    joy_a1 = 6'h00;
    joy_b1 = 6'h00;
    reset  = 1'b1;
    repeat (3) @(negedge pclk);
    check("reset_players", {j1, j2}, 12'hFFF);
    check("reset_sel_valid", {10'h0, sel0, v0}, 12'h000);
    check("reset_players_dut1", {k1, k2}, 12'hFFF);

    joy_a  = 6'h3F;
    joy_b  = 6'h3F;
    joy_a1 = 6'h3F;
    joy_b1 = 6'h3F;
    reset  = 1'b0;
    @(negedge pclk);

    // Static released input: check scan period and select duty.
    q0.push_back(12'hFFF);
    enable = 1'b1;
    wait_valid(1'b0, "first_scan");
    q0.push_back(12'hFFF);
    lows = 0;
    highs = 0;
    early = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge pclk);
      if (sel0) highs++;
      else lows++;
      if (i < 11 && v0) early++;
    end
    check("period_valid_at_11", {11'h0, v0}, 12'h001);
    check("period_no_early_valid", 12'(early), 12'd0);
    check("sel_low_cycles", 12'(lows), 12'd5);
    check("sel_high_cycles", 12'(highs), 12'd6);

    // Player 1 bit0 pressed: takes three scans to appear.
    scan0(6'h3E, 6'h3F, 6'h3F, 6'h3F, "p1_press_scan1");
    scan0(6'h3E, 6'h3F, 6'h3F, 6'h3F, "p1_press_scan2");
    scan0(6'h3E, 6'h3F, 6'h3E, 6'h3F, "p1_press_scan3");
    // Two-scan release glitch, broken by a matching sample, never reaches the output.
    scan0(6'h3F, 6'h3F, 6'h3E, 6'h3F, "glitch_1a");
    scan0(6'h3F, 6'h3F, 6'h3E, 6'h3F, "glitch_1b");
    scan0(6'h3E, 6'h3F, 6'h3E, 6'h3F, "glitch_break");
    scan0(6'h3F, 6'h3F, 6'h3E, 6'h3F, "glitch_2a");
    scan0(6'h3F, 6'h3F, 6'h3E, 6'h3F, "glitch_2b");
    // Player 2 bit5 pressed.
    scan0(6'h3E, 6'h1F, 6'h3E, 6'h3F, "p2_press_scan1");
    scan0(6'h3E, 6'h1F, 6'h3E, 6'h3F, "p2_press_scan2");
    scan0(6'h3E, 6'h1F, 6'h3E, 6'h1F, "p2_press_scan3");

    // Drop enable in the first SETTLE_B cycle.
    joy_a = 6'h3E;
    joy_b = 6'h3F;
    n = 0;
    while (!sel0 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("reach_settle_b", {11'h0, sel0}, 12'h001);
    enable = 1'b0;
    @(negedge pclk);
    check("abort_sel_valid", {10'h0, sel0, v0}, 12'h000);
    early = 0;
    repeat (15) begin
      @(negedge pclk);
      if (v0 || sel0) early++;
    end
    check("parked_no_valid_sel", 12'(early), 12'd0);
    check("abort_outputs_held", {j1, j2}, {6'h3E, 6'h1F});

    // Re-enable restarts at SETTLE_A; reset lands in SAMPLE_B.
    joy_b = 6'h1F;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!sel0 && n < 20);
    check("restart_sel_rise_cycle", 12'(n), 12'd6);
    repeat (4) @(negedge pclk);
    check("sample_b_sel_valid", {10'h0, sel0, v0}, 12'h002);
    check("pre_reset_outputs", {j1, j2}, {6'h3E, 6'h1F});
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check("async_reset_outputs", {j1, j2}, 12'hFFF);
    check("async_reset_sel_valid", {10'h0, sel0, v0}, 12'h000);

    repeat (2) @(negedge pclk);
    reset = 1'b0;
    @(negedge pclk);

    // Single-sample debounce follows every scan.
    scan1(6'h00, 6'h2A, 6'h00, 6'h2A, "deb1_scan1");
    scan1(6'h3F, 6'h15, 6'h3F, 6'h15, "deb1_scan2");
    scan1(6'h12, 6'h21, 6'h12, 6'h21, "deb1_scan3");
    scan1(6'h3F, 6'h3F, 6'h3F, 6'h3F, "deb1_scan4");
    enable1 = 1'b0;
    repeat (2) @(negedge pclk);

    check("queue0_drained", 12'(q0.size()), 12'd0);
    check("queue1_drained", 12'(q1.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
